prog_fetch: RTL and testbench

Instruction-fetch requester for the program ram. It owns the fetch pointer and drives the ram's Address port. It pairs each returned Data byte with the address that produced it, accounting for the ram's one-cycle registered read. Fetched bytes go to the decode stage through a valid/ready handshake backed by a 2-entry buffer, and a jump input redirects fetch and flushes stale words.

---
 rtl/prog_fetch.sv | 104 ++++++++++
 tb/tb_prog_fetch.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/prog_fetch.sv
// Instruction-fetch requester: owns the fetch pointer driving the program ram, pairs each
// registered-read Data byte with its address, and hands words to decode through a 2-entry buffer.
module prog_fetch #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int ROM_WORDS = 128,
    parameter int RESET_PC  = 0
) (
    input  logic              Clock,
    input  logic              nReset,
    output logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] Data,
    output logic [DATA_W-1:0] Instr,
    output logic [ADDR_W-1:0] InstrPC,
    output logic              InstrValid,
    input  logic              InstrReady,
    input  logic              Jump,
    input  logic [ADDR_W-1:0] JumpTarget
);

    localparam logic [ADDR_W-1:0] PC_MASK = ADDR_W'(ROM_WORDS - 1);
    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(ROM_WORDS - 1);
    localparam logic [ADDR_W-1:0] RST_PC  = ADDR_W'(RESET_PC);

    logic [ADDR_W-1:0] fpc;
    logic [ADDR_W-1:0] pend_pc;
    logic              pending;
    logic [1:0]        count;
    logic [DATA_W-1:0] buf_data0, buf_data1;
    logic [ADDR_W-1:0] buf_pc0, buf_pc1;

    logic       pop;
    logic       push;
    logic       issue;
    logic [2:0] occ_after_pop;

    // Handshake: a word transfers on any posedge where InstrValid and InstrReady are both 1;
    // while InstrValid=1 and InstrReady=0 the head word (Instr/InstrPC) is held unchanged.
    assign InstrValid = (count != 2'd0);
    assign Instr      = buf_data0;
    assign InstrPC    = buf_pc0;
    assign Address    = fpc;

    assign pop  = InstrValid & InstrReady;
    assign push = pending & ~Jump;

    // A new read is started only if its word is guaranteed a buffer slot when it lands.
    assign occ_after_pop = {1'b0, count} + {2'b00, pending} - {2'b00, pop};
    assign issue         = ~Jump & (occ_after_pop <= 3'd1);

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            fpc       <= RST_PC;
            pend_pc   <= '0;
            pending   <= 1'b0;
            count     <= 2'd0;
            buf_data0 <= '0;
            buf_data1 <= '0;
            buf_pc0   <= '0;
            buf_pc1   <= '0;
        end else if (Jump) begin
            // Any same-edge pop has already been taken by the consumer; everything else is stale.
            fpc     <= JumpTarget & PC_MASK;
            pending <= 1'b0;
            count   <= 2'd0;
        end else begin
            pending <= issue;
            if (issue) begin
                pend_pc <= fpc;
                fpc     <= (fpc == LAST_PC) ? '0 : fpc + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        buf_data0 <= Data;
                        buf_pc0   <= pend_pc;
                    end else begin
                        buf_data1 <= Data;
                        buf_pc1   <= pend_pc;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    buf_data0 <= buf_data1;
                    buf_pc0   <= buf_pc1;
                    count     <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        buf_data0 <= Data;
                        buf_pc0   <= pend_pc;
                    end else begin
                        buf_data0 <= buf_data1;
                        buf_pc0   <= buf_pc1;
                        buf_data1 <= Data;
                        buf_pc1   <= pend_pc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_fetch.sv
// Bench for prog_fetch: ram model, randomized ready/jump stimulus, and a sequence-level
// reference model feeding an expected queue that a negedge monitor checks against.
module tb_prog_fetch;

    localparam int ROM_WORDS = 128;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic [7:0] address;
    logic [7:0] data;
    logic [7:0] instr;
    logic [7:0] instr_pc;
    logic       instr_valid;
    logic       instr_ready = 1'b1;
    logic       jump = 1'b0;
    logic [7:0] jump_target = '0;

    logic [7:0]  mem [256];
    logic [15:0] exp_q [$];
    int          total = 0;
    int          bad = 0;
    int          n_pops = 0;
    bit          rst_flag = 1'b0;

    prog_fetch #(
        .ADDR_W(8), .DATA_W(8), .ROM_WORDS(ROM_WORDS), .RESET_PC(0)
    ) dut (
        .Clock(clk),
        .nReset(n_reset),
        .Address(address),
        .Data(data),
        .Instr(instr),
        .InstrPC(instr_pc),
        .InstrValid(instr_valid),
        .InstrReady(instr_ready),
        .Jump(jump),
        .JumpTarget(jump_target)
    );

    // clock / ram model
    always #5 clk = ~clk;
    always @(posedge clk) data <= mem[address];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic cyc(input bit rdy, input bit jmp, input logic [7:0] tgt);
        @(posedge clk);
        #2;
        instr_ready = rdy;
        jump        = jmp;
        jump_target = tgt;
    endtask

    task automatic rst_pulse();
        @(posedge clk);
        #1;
        n_reset = 1'b0;
        jump    = 1'b0;
        #1;
        chk("pulse_address", address, 0);
        chk("pulse_valid", instr_valid, 0);
        rst_flag = 1'b1;
        #1;
        n_reset = 1'b1;
    endtask

    // monitor / scoreboard
    initial begin
        int          nxt;
        int          since;
        bit          p1, p2;
        logic [7:0]  pi, pp, pa;
        logic [15:0] e;
        nxt = 0; since = 4; p1 = 0; p2 = 0; pi = '0; pp = '0; pa = '0;
        forever begin
            @(negedge clk);
            if (!n_reset) continue;
            if (rst_flag) begin
                exp_q.delete();
                nxt = 0; since = 1; p1 = 0; p2 = 0;
                rst_flag = 1'b0;
            end else if (since < 4) begin
                since++;
            end
            if (since >= 1 && since <= 3)
                chk("redirect_latency", instr_valid, since == 3);
            if (p1) begin
                chk("hold_valid", instr_valid, 1);
                chk("hold_instr", instr, pi);
                chk("hold_pc", instr_pc, pp);
                if (p2) chk("stall_address", address, pa);
            end
            if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    exp_q.push_back({mem[nxt[7:0]], nxt[7:0]});
                    nxt = (nxt + 1) % ROM_WORDS;
                end
                e = exp_q.pop_front();
                chk("instr_pc", instr_pc, e[7:0]);
                chk("instr", instr, e[15:8]);
                n_pops++;
            end
            p2 = p1;
            p1 = instr_valid && !instr_ready && !jump;
            pi = instr; pp = instr_pc; pa = address;
            if (jump) begin
                exp_q.delete();
                nxt = int'(jump_target) % ROM_WORDS;
                since = 0;
            end
        end
    end

    // stimulus
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
        n_reset = 1'b0; jump = 1'b1; jump_target = 8'h30; instr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_address", address, 0);
        chk("reset_valid", instr_valid, 0);
        chk("reset_instr", instr, 0);
        chk("reset_pc", instr_pc, 0);
        @(posedge clk);
        #2;
        jump = 1'b0;
        rst_flag = 1'b1;
        n_reset = 1'b1;

        for (int c = 0; c < 30; c++) cyc(!(c >= 5 && c < 11), 1'b0, 8'h00);

        repeat (4) cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 8'h40);
        repeat (6) cyc(1'b1, 1'b0, 8'h00);

        cyc(1'b1, 1'b1, 8'h7E);
        repeat (6) cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 8'hFE);
        repeat (6) cyc(1'b1, 1'b0, 8'h00);

        cyc(1'b1, 1'b1, 8'h10);
        cyc(1'b1, 1'b1, 8'h20);
        repeat (5) cyc(1'b1, 1'b0, 8'h00);

        repeat (3000) cyc($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, 8'($urandom));

        rst_pulse();
        repeat (3) cyc(1'b1, 1'b0, 8'h00);
        repeat (500) cyc($urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0, 8'($urandom));

        repeat (2) cyc(1'b0, 1'b0, 8'h00);
        rst_pulse();
        repeat (3) cyc(1'b1, 1'b0, 8'h00);
        repeat (200) cyc($urandom_range(0, 9) < 8, 1'b0, 8'h00);

        repeat (3) cyc(1'b0, 1'b0, 8'h00);
        chk("pops_seen", n_pops > 1000, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
